// File: rtl/hazard3_fetch_align_decompress.sv
// Fetch realignment and RVC expansion stage.
// Buffers 32-bit fetch words as halfwords, realigns 16/32-bit instructions
// (including word-straddling ones), expands RVC encodings, tracks the PC and
// propagates fetch bus errors to decode on a valid/ready interface.
module hazard3_fetch_align_decompress #(
  parameter bit                EXTENSION_C  = 1'b1,
  parameter int unsigned       DEPTH        = 2,
  parameter int unsigned       W_ADDR       = 32,
  parameter logic [W_ADDR-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [W_ADDR-1:0] flush_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic              out_is_32bit,
  output logic              out_invalid,
  output logic              out_err,
  output logic [W_ADDR-1:0] out_pc
);

  localparam int unsigned N_HW  = 2 * DEPTH;
  localparam int unsigned PTR_W = $clog2(N_HW);
  localparam int unsigned CNT_W = $clog2(N_HW + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  // Circular-buffer pointer increment; operands are always below 2*N_HW.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                               input logic [CNT_W-1:0] inc);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(ptr) + SUM_W'(inc);
    if (sum >= SUM_W'(N_HW)) sum = sum - SUM_W'(N_HW);
    return sum[PTR_W-1:0];
  endfunction

  logic [15:0]       hw_data [N_HW];
  logic              hw_err  [N_HW];
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  head;
  logic [W_ADDR-1:0] pc;
  logic              skip;

  logic [PTR_W-1:0]  head1, tail, tail1;
  logic [15:0]       h0, h1;
  logic              h0_err, h1_err;
  logic              push;
  logic [CNT_W-1:0]  push_n, pop_n, head_len;

  logic [31:0]       rvc_instr;
  logic              rvc_invalid;

  // Decode-side temporaries for the RVC expander
  logic [4:0]        c_rd, c_rs2, c_rdp, c_rs1p;
  logic [11:0]       c_imm6;
  logic [20:1]       c_joff;
  logic [12:1]       c_boff;
  logic [9:0]        c_imm_4spn;
  logic [6:0]        c_imm_lw;
  logic [9:0]        c_imm_16sp;
  logic [7:0]        c_imm_lwsp, c_imm_swsp;

  // Head / tail addressing and FIFO read ports
  always_comb begin
    head1  = ptr_add(head, CNT_W'(1));
    tail   = ptr_add(head, count);
    tail1  = ptr_add(tail, CNT_W'(1));
    h0     = hw_data[head];
    h0_err = hw_err[head];
    h1     = hw_data[head1];
    h1_err = hw_err[head1];
  end

  // Fetch-side handshake; skip drops the lower halfword after a misaligned redirect
  always_comb begin
    in_ready = rst_n && !flush && (count <= CNT_W'(N_HW - 2));
    push     = in_valid && in_ready;
    push_n   = push ? (skip ? CNT_W'(1) : CNT_W'(2)) : CNT_W'(0);
  end

  // RV32C expansion of the head halfword
  always_comb begin
    c_rd        = h0[11:7];
    c_rs2       = h0[6:2];
    c_rdp       = {2'b01, h0[4:2]};
    c_rs1p      = {2'b01, h0[9:7]};
    c_imm6      = {{6{h0[12]}}, h0[12], h0[6:2]};
    c_joff      = {{9{h0[12]}}, h0[12], h0[8], h0[10:9], h0[6], h0[7], h0[2], h0[11], h0[5:3]};
    c_boff      = {{4{h0[12]}}, h0[12], h0[6:5], h0[2], h0[11:10], h0[4:3]};
    c_imm_4spn  = {h0[10:7], h0[12:11], h0[5], h0[6], 2'b00};
    c_imm_lw    = {h0[5], h0[12:10], h0[6], 2'b00};
    c_imm_16sp  = {h0[12], h0[4:3], h0[5], h0[2], h0[6], 4'b0000};
    c_imm_lwsp  = {h0[3:2], h0[12], h0[6:4], 2'b00};
    c_imm_swsp  = {h0[8:7], h0[12:9], 2'b00};
    rvc_instr   = 32'h0;
    rvc_invalid = 1'b0;
    case ({h0[15:13], h0[1:0]})
      5'b000_00: begin // c.addi4spn
        rvc_instr   = {2'b00, c_imm_4spn, 5'd2, 3'b000, c_rdp, 7'b0010011};
        rvc_invalid = (c_imm_4spn == 10'd0);
      end
      5'b010_00: rvc_instr = {5'b0, c_imm_lw, c_rs1p, 3'b010, c_rdp, 7'b0000011};
      5'b110_00: rvc_instr = {5'b0, c_imm_lw[6:5], c_rdp, c_rs1p, 3'b010, c_imm_lw[4:0], 7'b0100011};
      5'b000_01: rvc_instr = {c_imm6, c_rd, 3'b000, c_rd, 7'b0010011};
      5'b001_01: rvc_instr = {c_joff[20], c_joff[10:1], c_joff[11], c_joff[19:12], 5'd1, 7'b1101111};
      5'b010_01: rvc_instr = {c_imm6, 5'd0, 3'b000, c_rd, 7'b0010011};
      5'b011_01: begin
        if (c_rd == 5'd2) begin // c.addi16sp
          rvc_instr   = {{2{h0[12]}}, c_imm_16sp, 5'd2, 3'b000, 5'd2, 7'b0010011};
          rvc_invalid = (c_imm_16sp == 10'd0);
        end else begin // c.lui
          rvc_instr   = {{15{h0[12]}}, h0[6:2], c_rd, 7'b0110111};
          rvc_invalid = ({h0[12], h0[6:2]} == 6'd0);
        end
      end
      5'b100_01: begin
        case (h0[11:10])
          2'b00: begin
            rvc_instr   = {7'b0000000, h0[6:2], c_rs1p, 3'b101, c_rs1p, 7'b0010011};
            rvc_invalid = h0[12];
          end
          2'b01: begin
            rvc_instr   = {7'b0100000, h0[6:2], c_rs1p, 3'b101, c_rs1p, 7'b0010011};
            rvc_invalid = h0[12];
          end
          2'b10: rvc_instr = {c_imm6, c_rs1p, 3'b111, c_rs1p, 7'b0010011};
          default: begin
            rvc_invalid = h0[12];
            case (h0[6:5])
              2'b00:   rvc_instr = {7'b0100000, c_rdp, c_rs1p, 3'b000, c_rs1p, 7'b0110011};
              2'b01:   rvc_instr = {7'b0000000, c_rdp, c_rs1p, 3'b100, c_rs1p, 7'b0110011};
              2'b10:   rvc_instr = {7'b0000000, c_rdp, c_rs1p, 3'b110, c_rs1p, 7'b0110011};
              default: rvc_instr = {7'b0000000, c_rdp, c_rs1p, 3'b111, c_rs1p, 7'b0110011};
            endcase
          end
        endcase
      end
      5'b101_01: rvc_instr = {c_joff[20], c_joff[10:1], c_joff[11], c_joff[19:12], 5'd0, 7'b1101111};
      5'b110_01: rvc_instr = {c_boff[12], c_boff[10:5], 5'd0, c_rs1p, 3'b000, c_boff[4:1], c_boff[11], 7'b1100011};
      5'b111_01: rvc_instr = {c_boff[12], c_boff[10:5], 5'd0, c_rs1p, 3'b001, c_boff[4:1], c_boff[11], 7'b1100011};
      5'b000_10: begin
        rvc_instr   = {7'b0000000, h0[6:2], c_rd, 3'b001, c_rd, 7'b0010011};
        rvc_invalid = h0[12];
      end
      5'b010_10: begin
        rvc_instr   = {4'b0, c_imm_lwsp, 5'd2, 3'b010, c_rd, 7'b0000011};
        rvc_invalid = (c_rd == 5'd0);
      end
      5'b100_10: begin
        if (!h0[12]) begin
          if (c_rs2 == 5'd0) begin // c.jr
            rvc_instr   = {12'b0, c_rd, 3'b000, 5'd0, 7'b1100111};
            rvc_invalid = (c_rd == 5'd0);
          end else begin // c.mv
            rvc_instr = {7'b0, c_rs2, 5'd0, 3'b000, c_rd, 7'b0110011};
          end
        end else if (c_rs2 == 5'd0) begin
          if (c_rd == 5'd0) rvc_instr = 32'h00100073; // c.ebreak
          else              rvc_instr = {12'b0, c_rd, 3'b000, 5'd1, 7'b1100111};
        end else begin // c.add
          rvc_instr = {7'b0, c_rs2, c_rd, 3'b000, c_rd, 7'b0110011};
        end
      end
      5'b110_10: rvc_instr = {4'b0, c_imm_swsp[7:5], c_rs2, 5'd2, 3'b010, c_imm_swsp[4:0], 7'b0100011};
      default:   rvc_invalid = 1'b1;
    endcase
    if (!EXTENSION_C) rvc_invalid = 1'b1;
    if (rvc_invalid)  rvc_instr   = 32'h0;
  end

  // Head evaluation: instruction length, presentation and pop size
  always_comb begin
    out_valid    = 1'b0;
    out_instr    = 32'h0;
    out_is_32bit = 1'b0;
    out_invalid  = 1'b0;
    out_err      = 1'b0;
    head_len     = CNT_W'(1);
    if (h0_err) begin
      out_valid = (count != '0);
      out_err   = 1'b1;
    end else if (h0[1:0] != 2'b11) begin
      out_valid   = (count != '0);
      out_instr   = rvc_instr;
      out_invalid = rvc_invalid;
    end else begin
      out_valid    = (count >= CNT_W'(2));
      out_instr    = {h1, h0};
      out_is_32bit = 1'b1;
      out_err      = h1_err;
      head_len     = CNT_W'(2);
    end
    if (flush) out_valid = 1'b0;
    pop_n = (out_valid && out_ready) ? head_len : CNT_W'(0);
  end

  assign out_pc = pc;

  // Halfword storage; lower halfword lands first unless skipped
  always_ff @(posedge clk) begin
    if (push) begin
      if (skip) begin
        hw_data[tail] <= in_data[31:16];
        hw_err[tail]  <= in_err;
      end else begin
        hw_data[tail]  <= in_data[15:0];
        hw_err[tail]   <= in_err;
        hw_data[tail1] <= in_data[31:16];
        hw_err[tail1]  <= in_err;
      end
    end
  end

  // Occupancy, head pointer, PC and skip tracking; flush overrides push/pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      head  <= '0;
      pc    <= RESET_VECTOR & ~W_ADDR'(1);
      skip  <= 1'b0;
    end else if (flush) begin
      count <= '0;
      pc    <= flush_addr & ~W_ADDR'(1);
      skip  <= flush_addr[1];
    end else begin
      count <= count + push_n - pop_n;
      head  <= ptr_add(head, pop_n);
      if (push) skip <= 1'b0;
      if (pop_n != '0) pc <= pc + (out_is_32bit ? W_ADDR'(4) : W_ADDR'(2));
    end
  end

endmodule
